// File: rtl/serial_feeder64.sv
// rtl/serial_feeder64.sv - parallel word to serial bit stream with shift strobe, flush and inter-frame gap
// Optional even-parity trailer bit: define SERIAL_FEEDER_PARITY_EN.
module serial_feeder64 #(
  parameter int N          = 64,
  parameter int GAP_CYCLES = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic         msb_first,
  input  logic         flush,
  output logic         ser_out,
  output logic         ser_en,
  output logic         frame_done,
  output logic         busy
);

  localparam int CW         = $clog2(N + 2);
  localparam int GW         = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  localparam logic [CW-1:0] N_C      = CW'(N);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LAST_I);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   shadow_q, shadow_d;
  logic           dir_q, dir_d;
  logic [CW-1:0]  count_q, count_d;
  logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
  logic           ser_out_q, ser_out_d;
  logic           ser_en_q, ser_en_d;
  logic           frame_done_q, frame_done_d;
`ifdef SERIAL_FEEDER_PARITY_EN
  logic           parity_q, parity_d;
`endif

  logic           next_bit;
  logic [N-1:0]   shifted;

  // The shadow register is consumed from the end selected at acceptance,
  // so the next bit is always at a fixed position.
  always_comb begin
    next_bit = dir_q ? shadow_q[N-1] : shadow_q[0];
    shifted  = dir_q ? {shadow_q[N-2:0], 1'b0} : {1'b0, shadow_q[N-1:1]};
  end

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    dir_d        = dir_q;
    count_d      = count_q;
    gap_cnt_d    = gap_cnt_q;
    ser_out_d    = 1'b0;
    ser_en_d     = 1'b0;
    frame_done_d = 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
    parity_d     = parity_q;
`endif

    if (flush) begin
      state_d   = IDLE;
      count_d   = '0;
      gap_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (din_valid) begin
            shadow_d  = msb_first ? {din[N-2:0], 1'b0} : {1'b0, din[N-1:1]};
            dir_d     = msb_first;
            ser_out_d = msb_first ? din[N-1] : din[0];
            ser_en_d  = 1'b1;
            count_d   = CW'(1);
            state_d   = SHIFT;
`ifdef SERIAL_FEEDER_PARITY_EN
            parity_d  = ^din;
`endif
          end
        end

        SHIFT: begin
          if (count_q < N_C) begin
            ser_out_d = next_bit;
            shadow_d  = shifted;
            ser_en_d  = 1'b1;
            count_d   = count_q + 1'b1;
`ifdef SERIAL_FEEDER_PARITY_EN
          end else if (count_q == N_C) begin
            ser_out_d = parity_q;
            ser_en_d  = 1'b1;
            count_d   = count_q + 1'b1;
`endif
          end else begin
            frame_done_d = 1'b1;
            count_d      = '0;
            gap_cnt_d    = '0;
            state_d      = (GAP_CYCLES > 0) ? GAP : IDLE;
          end
        end

        GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      shadow_q     <= '0;
      dir_q        <= 1'b0;
      count_q      <= '0;
      gap_cnt_q    <= '0;
      ser_out_q    <= 1'b0;
      ser_en_q     <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      dir_q        <= dir_d;
      count_q      <= count_d;
      gap_cnt_q    <= gap_cnt_d;
      ser_out_q    <= ser_out_d;
      ser_en_q     <= ser_en_d;
      frame_done_q <= frame_done_d;
`ifdef SERIAL_FEEDER_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign din_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign ser_out    = ser_out_q;
  assign ser_en     = ser_en_q;
  assign frame_done = frame_done_q;

endmodule
